// File: rtl/multicycle_main_control.sv
// multicycle_main_control: main control FSM for the multicycle MIPS-style core.
// It sequences fetch, decode, execute, memory and writeback, stalls on
// MemReady, and traps undecodable opcodes. Memory waits longer than
// MEM_WAIT_MAX cycles are abandoned and restart at FETCH.
// Optional build macro PERF_COUNTERS_EN adds the CycleCount and RetiredCount outputs.

module multicycle_main_control #(
   parameter int MEM_WAIT_MAX = 15,
   parameter int STATE_W      = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         Opcode,
   input  logic               MemReady,
   output logic [2:0]         ALUOpcode,
   output logic               PCWrite,
   output logic               PCWriteCond,
   output logic               IorD,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic               MemtoReg,
   output logic               RegDst,
   output logic               RegWrite,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         PCSource,
   output logic               IllegalOp,
   output logic               MemTimeout,
   output logic [STATE_W-1:0] State
`ifdef PERF_COUNTERS_EN
   ,
   output logic [31:0]        CycleCount,
   output logic [31:0]        RetiredCount
`endif
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // Count value seen on the last permitted wait cycle (1..255 fits in 8 bits).
   localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_REXEC   = 4'd6,
      S_RWB     = 4'd7,
      S_IEXEC   = 4'd8,
      S_IWB     = 4'd9,
      S_BEQ     = 4'd10,
      S_JUMP    = 4'd11,
      S_ILLEGAL = 4'd12
   } state_t;

   typedef struct packed {
      logic       fetch_wr;   // PCWrite/IRWrite of FETCH, still to be qualified by MemReady
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
      logic [2:0] alu_op;
      logic       illegal;
   } ctl_t;

   state_t     r_state;
   logic [7:0] r_wait;
   logic [5:0] r_op;
   ctl_t       r_ctl;

   state_t     w_next;
   logic       w_hold;
   logic       w_timeout;
   logic       w_retire;
   logic [5:0] w_op_next;
   ctl_t       w_ctl;

   // Opcode dispatch performed in DECODE.
   function automatic state_t dispatch(input logic [5:0] op);
      state_t s;
      case (op)
         OP_LW, OP_SW:                     s = S_MEMADR;
         OP_RTYPE:                         s = S_REXEC;
         OP_BEQ:                           s = S_BEQ;
         OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: s = S_IEXEC;
         OP_J:                             s = S_JUMP;
         default:                          s = S_ILLEGAL;
      endcase
      return s;
   endfunction

   // ALU operation for the immediate-type instructions.
   function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
      logic [2:0] a;
      case (op)
         OP_ANDI: a = 3'b011;
         OP_ORI:  a = 3'b100;
         OP_SLTI: a = 3'b111;
         default: a = 3'b000;
      endcase
      return a;
   endfunction

   // Moore output table: everything the datapath sees while in state s.
   function automatic ctl_t ctl_of(input state_t s, input logic [5:0] op);
      ctl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.mem_read  = 1'b1;
            c.fetch_wr  = 1'b1;
            c.alu_src_b = 2'b01;
         end
         S_DECODE: begin
            c.alu_src_b = 2'b11;
         end
         S_MEMADR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
         end
         S_MEMRD: begin
            c.mem_read = 1'b1;
            c.iord     = 1'b1;
         end
         S_MEMWB: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            c.mem_write = 1'b1;
            c.iord      = 1'b1;
         end
         S_REXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = 3'b010;
         end
         S_RWB: begin
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
         end
         S_IEXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
            c.alu_op    = imm_alu_op(op);
         end
         S_IWB: begin
            c.reg_write = 1'b1;
         end
         S_BEQ: begin
            c.alu_src_a     = 1'b1;
            c.alu_op        = 3'b001;
            c.pc_write_cond = 1'b1;
            c.pc_source     = 2'b01;
         end
         S_JUMP: begin
            c.pc_write  = 1'b1;
            c.pc_source = 2'b10;
         end
         S_ILLEGAL: begin
            c.illegal = 1'b1;
         end
         default: ;
      endcase
      return c;
   endfunction

   // Next-state selection, memory-wait holding and timeout detection.
   always_comb begin
      w_next    = r_state;
      w_hold    = 1'b0;
      w_timeout = 1'b0;
      case (r_state)
         S_FETCH: begin
            if (MemReady) w_next = S_DECODE;
            else          w_hold = 1'b1;
         end
         S_DECODE:  w_next = dispatch(Opcode);
         S_MEMADR:  w_next = (r_op == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD: begin
            if (MemReady) w_next = S_MEMWB;
            else          w_hold = 1'b1;
         end
         S_MEMWR: begin
            if (MemReady) w_next = S_FETCH;
            else          w_hold = 1'b1;
         end
         S_REXEC:   w_next = S_RWB;
         S_IEXEC:   w_next = S_IWB;
         S_MEMWB, S_RWB, S_IWB, S_BEQ, S_JUMP, S_ILLEGAL: w_next = S_FETCH;
         default:   w_next = S_FETCH;
      endcase
      if (w_hold && (r_wait == WAIT_LAST)) begin
         w_timeout = 1'b1;
         w_next    = S_FETCH;
      end
   end

   // An instruction retires when a completing state hands back to FETCH.
   always_comb begin
      w_retire = 1'b0;
      if ((w_next == S_FETCH) && !w_timeout) begin
         case (r_state)
            S_MEMWB, S_MEMWR, S_RWB, S_IWB, S_BEQ, S_JUMP: w_retire = 1'b1;
            default:                                        w_retire = 1'b0;
         endcase
      end
   end

   // The IEXEC ALU op must come from the opcode seen in DECODE, not a later one.
   assign w_op_next = (r_state == S_DECODE) ? Opcode : r_op;

   // State register, wait counter, opcode latch and registered control outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_FETCH;
         r_wait  <= '0;
         r_ctl   <= ctl_of(S_FETCH, 6'b000000);
      end else begin
         r_state <= w_next;
         r_wait  <= (w_hold && !w_timeout) ? r_wait + 8'd1 : 8'd0;
         r_ctl   <= ctl_of(w_next, w_op_next);
         if (r_state == S_DECODE) r_op <= Opcode;
      end
   end

   // While reset is held every control output sits at its inactive value.
   assign w_ctl = reset ? '0 : r_ctl;

   assign ALUOpcode   = w_ctl.alu_op;
   assign PCWrite     = w_ctl.pc_write | (w_ctl.fetch_wr & MemReady);
   assign PCWriteCond = w_ctl.pc_write_cond;
   assign IorD        = w_ctl.iord;
   assign MemRead     = w_ctl.mem_read;
   assign MemWrite    = w_ctl.mem_write;
   assign IRWrite     = w_ctl.fetch_wr & MemReady;
   assign MemtoReg    = w_ctl.mem_to_reg;
   assign RegDst      = w_ctl.reg_dst;
   assign RegWrite    = w_ctl.reg_write;
   assign ALUSrcA     = w_ctl.alu_src_a;
   assign ALUSrcB     = w_ctl.alu_src_b;
   assign PCSource    = w_ctl.pc_source;
   assign IllegalOp   = w_ctl.illegal;
   assign MemTimeout  = w_timeout & ~reset;
   assign State       = STATE_W'(r_state);

`ifdef PERF_COUNTERS_EN
   logic [31:0] r_cycle_cnt;
   logic [31:0] r_retired_cnt;

   // Free-running cycle counter and retired-instruction counter, both wrapping.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cycle_cnt   <= '0;
         r_retired_cnt <= '0;
      end else begin
         r_cycle_cnt <= r_cycle_cnt + 32'd1;
         if (w_retire) r_retired_cnt <= r_retired_cnt + 32'd1;
      end
   end

   assign CycleCount   = r_cycle_cnt;
   assign RetiredCount = r_retired_cnt;
`else
   logic w_unused_retire;
   assign w_unused_retire = w_retire;
`endif

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
Main control FSM for the multicycle MIPS-style processor. Decodes the 6-bit instruction opcode and sequences the datapath through the fetch, decode, execute, memory and writeback steps. Every cycle it drives the 3-bit ALU opcode consumed by the ALU control decoder, plus all datapath enables and mux selects. It stalls on a memory-ready handshake and traps illegal opcodes.

Parameters:
MEM_WAIT_MAX, 15, memory-ready timeout in cycles before raising MemTimeout (1..255)
STATE_W, 4, width of the exported state encoding

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; returns FSM to FETCH
Opcode  input  6  instruction[31:26] from the instruction register
MemReady  input  1  memory has completed the current read/write this cycle
ALUOpcode  output  3  to ALU control: 000 add, 001 sub, 010 R-type funct, 011 and, 100 or, 111 slt
PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA  output  1 each  datapath enables/selects
ALUSrcB  output  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
PCSource  output  2  00 ALU result, 01 ALUOut, 10 jump target
IllegalOp  output  1  one-cycle pulse on an undecodable opcode
MemTimeout  output  1  one-cycle pulse when a memory wait exceeds MEM_WAIT_MAX
State  output  STATE_W  current state, for debug

Behaviour:
- Reset: State=FETCH. All 1-bit outputs are 0, ALUSrcB=00, PCSource=00, ALUOpcode=000, wait counter=0. Reset wins over every other event, including mid-memory-wait.
- Outputs are Moore: a pure function of the registered state. Exception: PCWrite/IRWrite in FETCH are gated by MemReady.
- Wait handling: in FETCH, MEMRD and MEMWR, the FSM holds its state while MemReady=0.
- Wait counter:
  - Counts the cycles spent holding; clears on state exit.
  - When the count reaches MEM_WAIT_MAX, MemTimeout pulses and the FSM returns to FETCH, abandoning the access.
- Per-state outputs (unlisted outputs are 0):
  - FETCH: MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOpcode=000, PCSource=00. PCWrite and IRWrite assert only when MemReady=1. Moves to DECODE when MemReady=1.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOpcode=000 (branch target precompute). Next state by Opcode:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 (R-type) -> REXEC
    - 000100 (beq) -> BEQ
    - 001000 (addi) / 001100 (andi) / 001101 (ori) / 001010 (slti) -> IEXEC
    - 000010 (j) -> JUMP
    - anything else -> ILLEGAL
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOpcode=000. Goes to MEMRD for lw, MEMWR for sw.
  - MEMRD: MemRead, IorD=1. Goes to MEMWB when MemReady=1.
  - MEMWB: RegWrite, MemtoReg=1, RegDst=0. Goes to FETCH.
  - MEMWR: MemWrite, IorD=1. Goes to FETCH when MemReady=1.
  - REXEC: ALUSrcA=1, ALUSrcB=00, ALUOpcode=010. Goes to RWB.
  - RWB: RegWrite, RegDst=1, MemtoReg=0. Goes to FETCH.
  - IEXEC: ALUSrcA=1, ALUSrcB=10. ALUOpcode is 000 for addi, 011 for andi, 100 for ori, 111 for slti. The opcode is latched in DECODE, so later changes to the Opcode input are ignored. Goes to IWB.
  - IWB: RegWrite, RegDst=0, MemtoReg=0. Goes to FETCH.
  - BEQ: ALUSrcA=1, ALUSrcB=00, ALUOpcode=001, PCWriteCond, PCSource=01. Goes to FETCH.
  - JUMP: PCWrite, PCSource=10. Goes to FETCH.
  - ILLEGAL: IllegalOp=1 for exactly this one cycle; no other writes. Goes to FETCH.
- Instruction latency in cycles, excluding waits: lw 5, sw 4, R-type 4, I-type 4, beq 3, j 3, illegal 3.
- Unused state encodings recover to FETCH.

Optional Feature:
PERF_COUNTERS_EN.
- Defined:
  - Adds outputs CycleCount[31:0] and RetiredCount[31:0].
  - CycleCount increments every non-reset cycle.
  - RetiredCount increments on each transition into FETCH from MEMWB, MEMWR, RWB, IWB, BEQ or JUMP. It does not increment after ILLEGAL or a timeout.
  - Both counters wrap at 2^32, clear on reset, and their reset value is 0.
- Undefined: these ports and counters are absent. Behaviour is otherwise identical.

Test Plan:
- Reset held 3 cycles, then release with MemReady=1 -> FETCH outputs: MemRead=1, ALUSrcB=01, ALUOpcode=000, PCWrite=IRWrite=1.
- Opcode=000000, MemReady=1 -> states FETCH, DECODE, REXEC, RWB, FETCH; ALUOpcode=010 in REXEC; RegWrite=1 and RegDst=1 in RWB.
- Opcode=100011 with MemReady=0 for 3 cycles in MEMRD -> MEMRD held 3 extra cycles, then MEMWB with RegWrite=1 and MemtoReg=1; total 8 cycles.
- Opcode=001101 then 001010 -> ALUOpcode=100 in the first IEXEC and 111 in the second; Opcode changed mid-IEXEC has no effect.
- Opcode=111111 -> IllegalOp pulses exactly 1 cycle, then FETCH; RegWrite/MemWrite/PCWrite never assert during the ILLEGAL cycle.
- MEMWR with MemReady=0 held and MEM_WAIT_MAX=15 -> MemTimeout pulses on the 15th wait cycle, then FETCH. Reset asserted mid-MEMRD -> FETCH next cycle with all outputs at their reset values.
